// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, DEPTH-entry buffer to decode; ack->inst_valid is 1 cycle.
// Issue stalls while the buffer is full or fetch_err is set; pc_load flushes and redirects at the same edge.
module fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_load,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        r_state;
  logic [31:0]   r_fa;
  logic          r_imem_req;
  logic [31:0]   r_imem_addr;
  logic          r_fetch_err;
  logic [31:0]   r_buf_inst [DEPTH];
  logic [31:0]   r_buf_pc   [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_push;
  logic w_pop;
  logic w_issue;

  assign w_pop   = (r_count != '0) && inst_ready;
  assign w_push  = (r_state == REQ) && imem_ack && !pc_load;
  // Only issue from IDLE, so no request is in flight and count alone bounds the buffer.
  assign w_issue = (r_state == IDLE) && !pc_load && !r_fetch_err && (r_count < CNT_DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_fa        <= RESET_PC;
      r_imem_req  <= 1'b0;
      r_imem_addr <= 32'h0;
      r_fetch_err <= 1'b0;
    end else begin
      if (pc_load) begin
        r_fa        <= pc_in;
        r_fetch_err <= (pc_in[1:0] != 2'b00);
      end
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state     <= REQ;
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_fa;
          end
        end
        REQ: begin
          if (imem_ack) begin
            r_state    <= IDLE;
            r_imem_req <= 1'b0;
            if (!pc_load) r_fa <= r_fa + 32'd4;
          end else if (pc_load) begin
            r_state <= DROP;
          end
        end
        DROP: begin
          // Request stays up on the old address until memory completes it; the data is thrown away.
          if (imem_ack) begin
            r_state    <= IDLE;
            r_imem_req <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_inst[i] <= 32'h0;
        r_buf_pc[i]   <= 32'h0;
      end
    end else if (pc_load) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_buf_inst[r_wr_ptr] <= imem_rdata;
        r_buf_pc[r_wr_ptr]   <= r_fa;
        r_wr_ptr             <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_imem_addr;
  assign fetch_err  = r_fetch_err;
  assign inst_valid = (r_count != '0);
  assign inst       = r_buf_inst[r_rd_ptr];
  assign inst_pc    = r_buf_pc[r_rd_ptr];

endmodule
